riscv_fetch_unit: RTL and testbench

// Parametrised successor to the single-register IF stage: generates the fetch PC, issues

---
 rtl/riscv_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: issues pipelined imem requests, tracks outstanding fetches
// and buffers returned words with their PCs until ID consumes them.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | first cycle after reset release, no requests issued
// S_FETCH | normal operation, requests issued while credits remain
module riscv_fetch_unit #(
    parameter int                   WORD_SIZE   = 32,
    parameter int                   FETCH_DEPTH = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    output logic                           imem_req_o,
    output logic [WORD_SIZE-1:0]           imem_addr_o,
    input  logic                           imem_gnt_i,
    input  logic                           imem_rvalid_i,
    input  logic [WORD_SIZE-1:0]           imem_rdata_i,
    input  logic                           redirect_i,
    input  logic [WORD_SIZE-1:0]           redirect_pc_i,
    output logic                           instr_valid_o,
    output logic [WORD_SIZE-1:0]           instr_o,
    output logic [WORD_SIZE-1:0]           instr_pc_o,
    input  logic                           instr_ready_i,
    output logic [$clog2(FETCH_DEPTH):0]   fetch_count_o
);

    localparam int PW = $clog2(FETCH_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t               state_q, state_d;
    logic                 fetch_en;
    logic [WORD_SIZE-1:0] fetch_pc_q;
    logic [WORD_SIZE-1:0] redirect_pc_aligned;

    logic [WORD_SIZE-1:0] fifo_instr [FETCH_DEPTH];
    logic [WORD_SIZE-1:0] fifo_pc    [FETCH_DEPTH];
    logic [PW-1:0]        fifo_rd_q, fifo_wr_q;
    logic [CW-1:0]        fifo_cnt_q;

    // PCs of granted requests, popped in order as responses return
    logic [WORD_SIZE-1:0] pcq [FETCH_DEPTH];
    logic [PW-1:0]        pcq_rd_q, pcq_wr_q;

    logic [CW-1:0]        outst_q;
    logic [CW-1:0]        discard_q;
    logic [CW-1:0]        fetch_count;

    logic                 grant;
    logic                 push;
    logic                 pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fetch_en = 1'b0;
        case (state_q)
            S_IDLE:  state_d  = S_FETCH;
            S_FETCH: fetch_en = 1'b1;
        endcase
    end

    assign redirect_pc_aligned = redirect_pc_i & ~WORD_SIZE'(3);
    assign fetch_count         = fifo_cnt_q + outst_q;

    assign imem_req_o    = fetch_en && (fetch_count < CW'(FETCH_DEPTH)) && !redirect_i;
    assign imem_addr_o   = fetch_pc_q;
    assign grant         = imem_req_o && imem_gnt_i;
    assign push          = imem_rvalid_i && !redirect_i && (discard_q == '0);
    assign instr_valid_o = (fifo_cnt_q != '0) && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = fifo_instr[fifo_rd_q];
    assign instr_pc_o    = fifo_pc[fifo_rd_q];
    assign fetch_count_o = fetch_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                pcq[i]        <= '0;
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
            pcq_rd_q <= '0;
            pcq_wr_q <= '0;
        end else begin
            if (grant) begin
                pcq[pcq_wr_q] <= fetch_pc_q;
                pcq_wr_q      <= pcq_wr_q + PW'(1);
            end
            if (imem_rvalid_i) begin
                pcq_rd_q <= pcq_rd_q + PW'(1);
            end
            if (push) begin
                fifo_instr[fifo_wr_q] <= imem_rdata_i;
                fifo_pc[fifo_wr_q]    <= pcq[pcq_rd_q];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            outst_q <= outst_q + CW'(grant) - CW'(imem_rvalid_i);
            if (redirect_i) begin
                // a response landing in the redirect cycle is already dropped
                fetch_pc_q <= redirect_pc_aligned;
                fifo_rd_q  <= '0;
                fifo_wr_q  <= '0;
                fifo_cnt_q <= '0;
                discard_q  <= outst_q - CW'(imem_rvalid_i);
            end else begin
                if (grant) begin
                    fetch_pc_q <= fetch_pc_q + WORD_SIZE'(4);
                end
                if (push) begin
                    fifo_wr_q <= fifo_wr_q + PW'(1);
                end
                if (pop) begin
                    fifo_rd_q <= fifo_rd_q + PW'(1);
                end
                fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
                if (imem_rvalid_i && (discard_q != '0)) begin
                    discard_q <= discard_q - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: a behavioural memory and PC-stream model
// drive randomized traffic; a monitor compares every instruction ID accepts.
module tb_riscv_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic [2:0]  fetch_count_o;

    riscv_fetch_unit #(
        .WORD_SIZE  (32),
        .FETCH_DEPTH(DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_ready_i(instr_ready_i),
        .fetch_count_o(fetch_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_t;

    mem_t        mem_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          epoch = 0;
    int          fifo_model = 0;
    int          since_reset = 0;
    logic [31:0] model_pc = RST_PC;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // one clock cycle, entered and left at a falling edge
    task automatic one_cycle(input logic gnt, input logic rdy, input logic redir,
                             input logic [31:0] tgt, input int lat);
        logic rv;
        logic exp_req;
        logic exp_valid;
        int   exp_cnt;
        int   due;
        mem_t m;
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_gnt_i    = gnt;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? word_of(mem_q[0].addr) : $urandom();
        #1;
        exp_cnt   = mem_q.size() + fifo_model;
        exp_req   = (since_reset >= 1) && (exp_cnt < DEPTH) && !redir;
        exp_valid = (fifo_model > 0) && !redir;
        check("fetch_count", 32'(fetch_count_o), exp_cnt);
        check("imem_req", 32'(imem_req_o), 32'(exp_req));
        check("imem_addr", imem_addr_o, model_pc);
        check("instr_valid", 32'(instr_valid_o), 32'(exp_valid));
        if (rv) begin
            m = mem_q.pop_front();
            if (m.epoch == epoch && !redir) fifo_model++;
        end
        if (exp_valid && rdy) fifo_model--;
        if (exp_req && gnt) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            m.addr  = model_pc;
            m.due   = due;
            m.epoch = epoch;
            mem_q.push_back(m);
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        if (redir) begin
            epoch++;
            exp_q.delete();
            fifo_model = 0;
            model_pc = {tgt[31:2], 2'b00};
        end
        cyc++;
        since_reset++;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        rst_ni        = 1'b0;
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_count", 32'(fetch_count_o), 32'd0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_instr", instr_o, 32'd0);
        check("rst_instr_pc", instr_pc_o, 32'd0);
        repeat (2) @(negedge clk_i);
        mem_q.delete();
        exp_q.delete();
        fifo_model  = 0;
        model_pc    = RST_PC;
        since_reset = 0;
        epoch++;
        last_due = cyc;
        rst_ni   = 1'b1;
    endtask

    // monitor: every accepted instruction must match the next expected PC and word
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni && instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_instr: got pc %h, expected none", instr_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc_o, e);
                    check("instr_data", instr_o, word_of(e));
                end
            end
        end
    end

    initial begin
        int pg, pr, pd, lmax;
        do_reset();

        // streaming with single-cycle memory
        repeat (16) one_cycle(1'b1, 1'b1, 1'b0, '0, 1);

        // ID stalled: credits fill, then resume
        repeat (10) one_cycle(1'b1, 1'b0, 1'b0, '0, 1);
        check("credit_full", 32'(fetch_count_o), DEPTH);
        check("credit_req_low", 32'(imem_req_o), 32'd0);
        repeat (12) one_cycle(1'b1, 1'b1, 1'b0, '0, 1);

        // three outstanding, then redirect to an unaligned target
        repeat (10) one_cycle(1'b1, 1'b1, 1'b0, '0, 3);
        one_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103, 3);
        repeat (12) one_cycle(1'b1, 1'b1, 1'b0, '0, 3);

        // redirect coinciding with rvalid and a pop
        repeat (6) one_cycle(1'b1, 1'b1, 1'b0, '0, 1);
        one_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1);
        repeat (8) one_cycle(1'b1, 1'b1, 1'b0, '0, 1);

        // grant stalled, redirect mid-stall
        repeat (5) one_cycle(1'b0, 1'b1, 1'b0, '0, 1);
        one_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1);
        repeat (8) one_cycle(1'b1, 1'b1, 1'b0, '0, 2);

        // address wrap, then async reset mid-burst
        one_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF4, 1);
        repeat (10) one_cycle(1'b1, 1'b1, 1'b0, '0, 1);
        #2;
        do_reset();
        repeat (10) one_cycle(1'b1, 1'b1, 1'b0, '0, 1);

        // redirect while still idle
        do_reset();
        one_cycle(1'b1, 1'b1, 1'b1, 32'h0000_2002, 1);
        repeat (10) one_cycle(1'b1, 1'b1, 1'b0, '0, 2);

        // randomized traffic with changing knobs
        for (int blk = 0; blk < 15; blk++) begin
            pg   = $urandom_range(20, 100);
            pr   = $urandom_range(20, 100);
            pd   = $urandom_range(0, 8);
            lmax = $urandom_range(1, 4);
            for (int i = 0; i < 200; i++) begin
                one_cycle($urandom_range(0, 99) < pg, $urandom_range(0, 99) < pr,
                          $urandom_range(0, 99) < pd, $urandom(),
                          $urandom_range(1, lmax));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
